ball_physics_engine: RTL and testbench

//  Fixed-point kinematics for N_BALLS independent pinball balls: gravity, bounce, flipper kick, impulses, speed clamp.
//  Per-ball lifecycle FSM (PARKED/ACTIVE/LOST) with launch arbitration and drain detection.

---
 rtl/ball_physics_engine_pkg.sv | 42 ++++
 rtl/ball_physics_engine_if.sv | 40 ++++
 rtl/ball_physics_engine_channel.sv | 168 ++++++++++++++++
 rtl/ball_physics_engine.sv | 76 +++++++
 tb/tb_ball_physics_engine.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ball_physics_engine_pkg.sv
// Shared widths, ball lifecycle encoding and speed helpers for the ball physics engine.
package ball_physics_engine_pkg;

    localparam int POS_W      = 11;                       // signed pixel coordinate width
    localparam int SPD_W      = 16;                       // signed fixed-point speed width
    localparam int FRAC_BITS  = 6;                        // fractional bits of speed/position
    localparam int DAMP_SHIFT = 3;                        // restitution shift for damped bounces
    localparam int SUM_W      = SPD_W + 2;                // headroom for speed sums before clamping
    localparam int PFX_W      = POS_W + FRAC_BITS + 1;    // fixed-point position width

    typedef enum logic [1:0] {
        PARKED = 2'd0,
        ACTIVE = 2'd1,
        LOST   = 2'd2
    } ball_state_e;

    typedef logic signed [SPD_W-1:0] spd_t;
    typedef logic signed [SUM_W-1:0] sum_t;
    typedef logic signed [PFX_W-1:0] pos_t;

    // Sign-extend a speed into the wide summing format.
    function automatic sum_t sx_spd(input spd_t v);
        return {{(SUM_W-SPD_W){v[SPD_W-1]}}, v};
    endfunction

    // Sign-extend a speed into the position format.
    function automatic pos_t sx_pos(input spd_t v);
        return {{(PFX_W-SPD_W){v[SPD_W-1]}}, v};
    endfunction

    // Saturate a wide speed sum into [-lim, +lim].
    function automatic spd_t clamp_spd(input sum_t v, input sum_t lim);
        sum_t neg_lim;
        neg_lim = -lim;
        if (v > lim)
            return lim[SPD_W-1:0];
        else if (v < neg_lim)
            return neg_lim[SPD_W-1:0];
        return v[SPD_W-1:0];
    endfunction

endpackage

// File: rtl/ball_physics_engine_if.sv
// Control, collision and pixel-output bundle between the game logic and the ball physics engine.
interface ball_physics_engine_if
    import ball_physics_engine_pkg::*;
#(
    parameter int N_BALLS = 2
);
    logic                       startOfFrame;
    logic                       pause;
    logic                       reset_level;
    logic                       launch;
    logic [N_BALLS-1:0]         colTop;
    logic [N_BALLS-1:0]         colLeft;
    logic [N_BALLS-1:0]         colRight;
    logic [N_BALLS-1:0]         colFlipper;
    logic [N_BALLS-1:0]         colObstacle;
    logic [N_BALLS*4-1:0]       hitEdgeCode;
    logic signed [SPD_W-1:0]    flipperSpeedX;
    logic [N_BALLS-1:0]         impulseValid;
    logic signed [SPD_W-1:0]    impulseX;
    logic signed [SPD_W-1:0]    impulseY;
    logic [N_BALLS*POS_W-1:0]   topLeftX;
    logic [N_BALLS*POS_W-1:0]   topLeftY;
    logic [N_BALLS*2-1:0]       ballState;
    logic [N_BALLS-1:0]         ballLostPulse;
    logic                       allLost;

    modport master (
        output startOfFrame, pause, reset_level, launch,
        output colTop, colLeft, colRight, colFlipper, colObstacle, hitEdgeCode,
        output flipperSpeedX, impulseValid, impulseX, impulseY,
        input  topLeftX, topLeftY, ballState, ballLostPulse, allLost
    );

    modport slave (
        input  startOfFrame, pause, reset_level, launch,
        input  colTop, colLeft, colRight, colFlipper, colObstacle, hitEdgeCode,
        input  flipperSpeedX, impulseValid, impulseX, impulseY,
        output topLeftX, topLeftY, ballState, ballLostPulse, allLost
    );
endinterface

// File: rtl/ball_physics_engine_channel.sv
// One ball channel: lifecycle FSM, speed with bounce/kick/impulse/gravity, clamped, and position.
// Optional PHYS_DAMPING_EN: bounces lose |v| >> DAMP_SHIFT of magnitude instead of exact negation.
module ball_physics_channel
    import ball_physics_engine_pkg::*;
#(
    parameter int GRAVITY      = 2,
    parameter int MAX_SPEED    = 1024,
    parameter int LAUNCH_SPEED = 512,
    parameter int INIT_X       = 300,
    parameter int INIT_Y       = 400,
    parameter int BOTTOM_Y     = 479
) (
    input  logic             clk,
    input  logic             i_rst,
    input  logic             i_frame,
    input  logic             i_pause,
    input  logic             i_level_rst,
    input  logic             i_grant,
    input  logic             i_col_top,
    input  logic             i_col_left,
    input  logic             i_col_right,
    input  logic             i_col_flipper,
    input  logic             i_col_obstacle,
    input  logic [3:0]       i_edge,
    input  spd_t             i_flip_spd_x,
    input  logic             i_imp_valid,
    input  spd_t             i_imp_x,
    input  spd_t             i_imp_y,
    output logic [POS_W-1:0] o_pix_x,
    output logic [POS_W-1:0] o_pix_y,
    output logic [1:0]       o_state,
    output logic             o_lost_pulse
);

    localparam sum_t L_MAX    = sum_t'(MAX_SPEED);
    localparam sum_t L_GRAV   = sum_t'(GRAVITY);
    localparam spd_t L_LAUNCH = spd_t'(-LAUNCH_SPEED);
    localparam pos_t L_INIT_X = pos_t'(INIT_X * (2 ** FRAC_BITS));
    localparam pos_t L_INIT_Y = pos_t'(INIT_Y * (2 ** FRAC_BITS));
    localparam pos_t L_BOTTOM = pos_t'(BOTTOM_Y);

    ball_state_e r_state, w_state_next;
    spd_t        r_vx, r_vy, w_vx_next, w_vy_next;
    pos_t        r_px, r_py, w_px_next, w_py_next;
    logic        r_lost_pulse, w_lost_pulse_next;

    logic        w_vx_neg, w_vx_pos, w_vy_neg, w_vy_pos;
    logic        w_flip_x, w_flip_y, w_kick, w_lost_now;
    sum_t        w_vx_sum, w_vy_sum;
    spd_t        w_vx_evt, w_vy_evt, w_vy_grav;
    pos_t        w_px_frame, w_py_frame, w_py_frame_pix;

    // Reverse a speed; damped builds also shave a fraction off the magnitude.
    function automatic sum_t flip_spd(input spd_t v);
        sum_t v_ext;
`ifdef PHYS_DAMPING_EN
        sum_t mag;
`endif
        v_ext = sx_spd(v);
`ifdef PHYS_DAMPING_EN
        mag = v_ext[SUM_W-1] ? -v_ext : v_ext;
        mag = mag - (mag >>> DAMP_SHIFT);
        return v_ext[SUM_W-1] ? mag : -mag;
`else
        return -v_ext;
`endif
    endfunction

    // Event speed (bounce, kick, impulse), gravity step and frame position from current registers.
    always_comb begin
        w_vx_neg   = r_vx[SPD_W-1];
        w_vx_pos   = !r_vx[SPD_W-1] && (r_vx != '0);
        w_vy_neg   = r_vy[SPD_W-1];
        w_vy_pos   = !r_vy[SPD_W-1] && (r_vy != '0);
        // A surface only reflects a ball that is moving into it.
        w_flip_x   = ((i_col_left  || (i_col_obstacle && i_edge[3])) && w_vx_neg) ||
                     ((i_col_right || (i_col_obstacle && i_edge[1])) && w_vx_pos);
        w_flip_y   = ((i_col_top     || (i_col_obstacle && i_edge[2])) && w_vy_neg) ||
                     ((i_col_flipper || (i_col_obstacle && i_edge[0])) && w_vy_pos);
        w_kick     = i_col_flipper && w_vy_pos;
        w_vx_sum   = (w_flip_x ? flip_spd(r_vx) : sx_spd(r_vx)) +
                     (w_kick ? sx_spd(i_flip_spd_x) : '0) +
                     (i_imp_valid ? sx_spd(i_imp_x) : '0);
        w_vy_sum   = (w_flip_y ? flip_spd(r_vy) : sx_spd(r_vy)) +
                     (i_imp_valid ? sx_spd(i_imp_y) : '0);
        w_vx_evt   = clamp_spd(w_vx_sum, L_MAX);
        w_vy_evt   = clamp_spd(w_vy_sum, L_MAX);
        w_vy_grav  = clamp_spd(sx_spd(w_vy_evt) + L_GRAV, L_MAX);
        // Position advances with the speed held before this cycle's events.
        w_px_frame = r_px + sx_pos(r_vx);
        w_py_frame = r_py + sx_pos(r_vy);
        w_py_frame_pix = w_py_frame >>> FRAC_BITS;
        w_lost_now = (w_py_frame_pix > L_BOTTOM);
    end

    // Lifecycle next-state: level reset parks, pause freezes, launch grant and drain move on.
    always_comb begin
        w_state_next = r_state;
        if (i_level_rst) begin
            w_state_next = PARKED;
        end else if (!i_pause) begin
            case (r_state)
                PARKED:  if (i_grant) w_state_next = ACTIVE;
                ACTIVE:  if (i_frame && w_lost_now) w_state_next = LOST;
                LOST:    w_state_next = LOST;
                default: w_state_next = PARKED;
            endcase
        end
    end

    // Datapath outputs of the FSM: speed, position and drain pulse for the next cycle.
    always_comb begin
        w_vx_next         = r_vx;
        w_vy_next         = r_vy;
        w_px_next         = r_px;
        w_py_next         = r_py;
        w_lost_pulse_next = 1'b0;
        if (i_level_rst) begin
            w_vx_next = '0;
            w_vy_next = '0;
            w_px_next = L_INIT_X;
            w_py_next = L_INIT_Y;
        end else if (!i_pause) begin
            if ((r_state == PARKED) && i_grant) begin
                w_vx_next = '0;
                w_vy_next = L_LAUNCH;
            end else if (r_state == ACTIVE) begin
                w_vx_next = w_vx_evt;
                w_vy_next = w_vy_evt;
                if (i_frame) begin
                    w_px_next         = w_px_frame;
                    w_py_next         = w_py_frame;
                    w_vy_next         = w_vy_grav;
                    w_lost_pulse_next = w_lost_now;
                end
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (i_rst) r_state <= PARKED;
        else       r_state <= w_state_next;
    end

    // Speed, position and pulse registers.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_vx         <= '0;
            r_vy         <= '0;
            r_px         <= L_INIT_X;
            r_py         <= L_INIT_Y;
            r_lost_pulse <= 1'b0;
        end else begin
            r_vx         <= w_vx_next;
            r_vy         <= w_vy_next;
            r_px         <= w_px_next;
            r_py         <= w_py_next;
            r_lost_pulse <= w_lost_pulse_next;
        end
    end

    assign o_pix_x      = r_px[FRAC_BITS +: POS_W];
    assign o_pix_y      = r_py[FRAC_BITS +: POS_W];
    assign o_state      = r_state;
    assign o_lost_pulse = r_lost_pulse;

endmodule

// File: rtl/ball_physics_engine.sv
// Multi-ball physics top: launch priority to the lowest parked ball, drain summary, channel array.
// Optional PHYS_DAMPING_EN selects damped bounces inside every channel.
module ball_physics_engine
    import ball_physics_engine_pkg::*;
#(
    parameter int N_BALLS      = 2,
    parameter int GRAVITY      = 2,
    parameter int MAX_SPEED    = 1024,
    parameter int LAUNCH_SPEED = 512,
    parameter int INIT_X       = 300,
    parameter int INIT_Y       = 400,
    parameter int BOTTOM_Y     = 479
) (
    input logic                  clk,
    input logic                  reset,
    ball_physics_engine_if.slave bus
);

    logic [N_BALLS-1:0] w_parked, w_active, w_lost, w_grant;
    logic               w_launch_ok;

    assign w_launch_ok = bus.launch && !bus.pause && !bus.reset_level;

    // Launch goes to the lowest-index parked ball only.
    always_comb begin
        logic found;
        found   = 1'b0;
        w_grant = '0;
        for (int i = 0; i < N_BALLS; i++) begin
            if (w_launch_ok && w_parked[i] && !found) begin
                w_grant[i] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    assign bus.allLost = !(|w_active) && (|w_lost);

    generate
        for (genvar gi = 0; gi < N_BALLS; gi++) begin : g_ball
            ball_physics_channel #(
                .GRAVITY      (GRAVITY),
                .MAX_SPEED    (MAX_SPEED),
                .LAUNCH_SPEED (LAUNCH_SPEED),
                .INIT_X       (INIT_X),
                .INIT_Y       (INIT_Y),
                .BOTTOM_Y     (BOTTOM_Y)
            ) u_chan (
                .clk            (clk),
                .i_rst          (reset),
                .i_frame        (bus.startOfFrame),
                .i_pause        (bus.pause),
                .i_level_rst    (bus.reset_level),
                .i_grant        (w_grant[gi]),
                .i_col_top      (bus.colTop[gi]),
                .i_col_left     (bus.colLeft[gi]),
                .i_col_right    (bus.colRight[gi]),
                .i_col_flipper  (bus.colFlipper[gi]),
                .i_col_obstacle (bus.colObstacle[gi]),
                .i_edge         (bus.hitEdgeCode[gi*4 +: 4]),
                .i_flip_spd_x   (bus.flipperSpeedX),
                .i_imp_valid    (bus.impulseValid[gi]),
                .i_imp_x        (bus.impulseX),
                .i_imp_y        (bus.impulseY),
                .o_pix_x        (bus.topLeftX[gi*POS_W +: POS_W]),
                .o_pix_y        (bus.topLeftY[gi*POS_W +: POS_W]),
                .o_state        (bus.ballState[gi*2 +: 2]),
                .o_lost_pulse   (bus.ballLostPulse[gi])
            );
            assign w_parked[gi] = (bus.ballState[gi*2 +: 2] == PARKED);
            assign w_active[gi] = (bus.ballState[gi*2 +: 2] == ACTIVE);
            assign w_lost[gi]   = (bus.ballState[gi*2 +: 2] == LOST);
        end
    endgenerate

endmodule

// File: tb/tb_ball_physics_engine.sv
// Testbench: directed scenarios with literal expectations plus randomized traffic, all checked
// every cycle against an integer kinematics model of the ball rules.
module tb_ball_physics_engine;
    import ball_physics_engine_pkg::*;

    localparam int N    = 2;
    localparam int G    = 2;
    localparam int MAXS = 1024;
    localparam int LS   = 512;
    localparam int IX   = 300;
    localparam int IY   = 400;
    localparam int BOT  = 479;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ball_physics_engine_if #(.N_BALLS(N)) bus_if ();
    ball_physics_engine #(.N_BALLS(N)) dut (.clk(clk), .reset(reset), .bus(bus_if));

    int checks = 0;
    int errors = 0;

    // model: state 0 parked, 1 active, 2 lost; speeds/positions in 1/64 pixel units
    int m_state [N];
    int m_vx [N];
    int m_vy [N];
    int m_px [N];
    int m_py [N];
    int m_pulse [N];

    task automatic chk(input string name, input int idx, input logic [31:0] act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got %0d expected %0d at %0t", name, idx, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] st(input int i);  return 32'(bus_if.ballState[i*2 +: 2]);        endfunction
    function automatic logic [31:0] pxl(input int i); return 32'(bus_if.topLeftX[i*POS_W +: POS_W]); endfunction
    function automatic logic [31:0] pyl(input int i); return 32'(bus_if.topLeftY[i*POS_W +: POS_W]); endfunction
    function automatic logic [31:0] pl(input int i);  return 32'(bus_if.ballLostPulse[i]);           endfunction

    function automatic int clampv(input int v);
        if (v > MAXS)  return MAXS;
        if (v < -MAXS) return -MAXS;
        return v;
    endfunction

    function automatic int bounce(input int v);
`ifdef PHYS_DAMPING_EN
        int mag;
        mag = (v < 0) ? -v : v;
        mag = mag - (mag >> 3);
        return (v < 0) ? mag : -mag;
`else
        return -v;
`endif
    endfunction

    // positions are 18-bit signed quantities
    function automatic int wrap18(input int v);
        int t;
        t = v <<< 14;
        return t >>> 14;
    endfunction

    task automatic park_all();
        for (int i = 0; i < N; i++) begin
            m_state[i] = 0; m_vx[i] = 0; m_vy[i] = 0;
            m_px[i] = IX * 64; m_py[i] = IY * 64; m_pulse[i] = 0;
        end
    endtask

    task automatic step_ball(input int i);
        int ex, ey;
        logic [3:0] e;
        logic obs;
        e   = bus_if.hitEdgeCode[i*4 +: 4];
        obs = bus_if.colObstacle[i];
        ex  = m_vx[i];
        ey  = m_vy[i];
        if (m_vx[i] < 0 && (bus_if.colLeft[i]    || (obs && e[3]))) ex = bounce(m_vx[i]);
        if (m_vx[i] > 0 && (bus_if.colRight[i]   || (obs && e[1]))) ex = bounce(m_vx[i]);
        if (m_vy[i] < 0 && (bus_if.colTop[i]     || (obs && e[2]))) ey = bounce(m_vy[i]);
        if (m_vy[i] > 0 && (bus_if.colFlipper[i] || (obs && e[0]))) ey = bounce(m_vy[i]);
        if (bus_if.colFlipper[i] && m_vy[i] > 0) ex += int'(bus_if.flipperSpeedX);
        if (bus_if.impulseValid[i]) begin
            ex += int'(bus_if.impulseX);
            ey += int'(bus_if.impulseY);
        end
        ex = clampv(ex);
        ey = clampv(ey);
        if (bus_if.startOfFrame) begin
            m_px[i] = wrap18(m_px[i] + m_vx[i]);
            m_py[i] = wrap18(m_py[i] + m_vy[i]);
            ey = clampv(ey + G);
            if ((m_py[i] >>> 6) > BOT) begin
                m_state[i] = 2;
                m_pulse[i] = 1;
            end
        end
        m_vx[i] = ex;
        m_vy[i] = ey;
    endtask

    // reference model advances on the same edge the design registers on
    always @(posedge clk) begin
        int g;
        if (reset || bus_if.reset_level) begin
            park_all();
        end else begin
            for (int i = 0; i < N; i++) m_pulse[i] = 0;
            if (!bus_if.pause) begin
                g = -1;
                if (bus_if.launch)
                    for (int i = 0; i < N; i++) if (g < 0 && m_state[i] == 0) g = i;
                for (int i = 0; i < N; i++) begin
                    if (i == g) begin
                        m_state[i] = 1; m_vx[i] = 0; m_vy[i] = -LS;
                    end else if (m_state[i] == 1) begin
                        step_ball(i);
                    end
                end
            end
        end
    end

    // every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        int any_active, any_lost;
        any_active = 0; any_lost = 0;
        for (int i = 0; i < N; i++) begin
            chk("model_state", i, st(i),  m_state[i]);
            chk("model_pixX",  i, pxl(i), (m_px[i] >>> 6) & 2047);
            chk("model_pixY",  i, pyl(i), (m_py[i] >>> 6) & 2047);
            chk("model_pulse", i, pl(i),  m_pulse[i]);
            if (m_state[i] == 1) any_active = 1;
            if (m_state[i] == 2) any_lost = 1;
        end
        chk("model_allLost", 0, 32'(bus_if.allLost), (any_active == 0 && any_lost == 1) ? 1 : 0);
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus_if.startOfFrame = 1'b0; bus_if.pause = 1'b0; bus_if.reset_level = 1'b0; bus_if.launch = 1'b0;
        bus_if.colTop = '0; bus_if.colLeft = '0; bus_if.colRight = '0; bus_if.colFlipper = '0;
        bus_if.colObstacle = '0; bus_if.hitEdgeCode = '0; bus_if.flipperSpeedX = '0;
        bus_if.impulseValid = '0; bus_if.impulseX = '0; bus_if.impulseY = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1; tick(); reset = 1'b0;
    endtask

    task automatic frame();
        bus_if.startOfFrame = 1'b1; tick(); bus_if.startOfFrame = 1'b0;
    endtask

    task automatic impulse(input logic [N-1:0] which, input int iy);
        bus_if.impulseValid = which; bus_if.impulseY = spd_t'(iy); tick();
        bus_if.impulseValid = '0; bus_if.impulseY = '0;
    endtask

    task automatic launch_one();
        bus_if.launch = 1'b1; tick(); bus_if.launch = 1'b0;
    endtask

    initial begin
        int found;
        reset = 1'b1;
        clear_inputs();
        tick();
        reset = 1'b0;

        // 1: reset state
        for (int i = 0; i < N; i++) begin
            chk("t1_state", i, st(i), 0);
            chk("t1_x", i, pxl(i), 300);
            chk("t1_y", i, pyl(i), 400);
            chk("t1_pulse", i, pl(i), 0);
        end
        chk("t1_allLost", 0, 32'(bus_if.allLost), 0);
        $display("T1 reset: state0=%0d x0=%0d y0=%0d", st(0), pxl(0), pyl(0));

        // 2: launch sequence and arbitration
        launch_one();
        chk("t2_state", 0, st(0), 1);
        chk("t2_state", 1, st(1), 0);
        frame();
        chk("t2_y_f1", 0, pyl(0), 392);
        frame();
        chk("t2_y_f2", 0, pyl(0), 384);
        launch_one();
        chk("t2_state_l2", 1, st(1), 1);
        launch_one();
        chk("t2_state_l3", 0, st(0), 1);
        chk("t2_state_l3", 1, st(1), 1);
        chk("t2_y_l3", 1, pyl(1), 400);
        $display("T2 launch: y0=%0d state1=%0d", pyl(0), st(1));

        // 3: top bounce with frame in the same cycle
        do_reset();
        launch_one();
        impulse(2'b01, 412);
        bus_if.colTop = 2'b01; frame(); bus_if.colTop = '0;
        chk("t3_y_bounce", 0, pyl(0), 398);
        frame();
`ifdef PHYS_DAMPING_EN
        chk("t3_y_after", 0, pyl(0), 399);
`else
        chk("t3_y_after", 0, pyl(0), 400);
`endif
        $display("T3 bounce: y0=%0d", pyl(0));

        // 4: clamp at both ends
        do_reset();
        launch_one();
        impulse(2'b01, 1535);
        frame();
        chk("t4_y_1023", 0, pyl(0), 415);
        frame();
        chk("t4_y_clamp_hi", 0, pyl(0), 431);
        impulse(2'b01, -1024);
        impulse(2'b01, -3000);
        frame();
        chk("t4_y_clamp_lo", 0, pyl(0), 415);
        frame();
        chk("t4_y_after", 0, pyl(0), 400);
        $display("T4 clamp: y0=%0d", pyl(0));

        // 5: drain, allLost, level reset
        do_reset();
        launch_one();
        launch_one();
        impulse(2'b01, 1536);
        for (int k = 0; k < 4; k++) frame();
        chk("t5_pre_state", 0, st(0), 1);
        chk("t5_pre_pulse", 0, pl(0), 0);
        frame();
        chk("t5_pulse", 0, pl(0), 1);
        chk("t5_state", 0, st(0), 2);
        chk("t5_y_lost", 0, pyl(0), 480);
        chk("t5_allLost_one", 0, 32'(bus_if.allLost), 0);
        tick();
        chk("t5_pulse_end", 0, pl(0), 0);
        frame();
        chk("t5_y_frozen", 0, pyl(0), 480);
        impulse(2'b10, 3000);
        found = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            frame();
            if (st(1) == 2) begin
                found = 1;
                chk("t5_pulse", 1, pl(1), 1);
            end
        end
        chk("t5_state", 1, st(1), 2);
        chk("t5_allLost", 0, 32'(bus_if.allLost), 1);
        bus_if.reset_level = 1'b1; tick(); bus_if.reset_level = 1'b0;
        chk("t5_lvl_state", 0, st(0), 0);
        chk("t5_lvl_state", 1, st(1), 0);
        chk("t5_lvl_y", 0, pyl(0), 400);
        chk("t5_lvl_allLost", 0, 32'(bus_if.allLost), 0);
        $display("T5 drain: allLost=%0d state0=%0d", bus_if.allLost, st(0));

        // 6: pause freezes everything; reset mid-flight
        do_reset();
        launch_one();
        frame();
        bus_if.pause = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus_if.colTop = 2'b11; bus_if.launch = 1'b1; frame();
            tick();
        end
        bus_if.colTop = '0; bus_if.launch = 1'b0;
        chk("t6_state", 0, st(0), 1);
        chk("t6_state", 1, st(1), 0);
        chk("t6_y_frozen", 0, pyl(0), 392);
        bus_if.pause = 1'b0;
        frame();
        chk("t6_y_resume", 0, pyl(0), 384);
        do_reset();
        chk("t6_rst_state", 0, st(0), 0);
        chk("t6_rst_x", 0, pxl(0), 300);
        chk("t6_rst_y", 0, pyl(0), 400);
        $display("T6 pause/reset: state0=%0d y0=%0d", st(0), pyl(0));

        // randomized traffic, checked every cycle by the compare process
        for (int c = 0; c < 4000; c++) begin
            bus_if.startOfFrame  = ($urandom_range(0, 1) == 0);
            bus_if.pause         = ($urandom_range(0, 15) == 0);
            bus_if.reset_level   = ($urandom_range(0, 299) == 0);
            bus_if.launch        = ($urandom_range(0, 7) == 0);
            bus_if.colTop        = N'($urandom) & N'($urandom) & N'($urandom);
            bus_if.colLeft       = N'($urandom) & N'($urandom) & N'($urandom);
            bus_if.colRight      = N'($urandom) & N'($urandom) & N'($urandom);
            bus_if.colFlipper    = N'($urandom) & N'($urandom) & N'($urandom);
            bus_if.colObstacle   = N'($urandom) & N'($urandom) & N'($urandom);
            bus_if.hitEdgeCode   = (N*4)'($urandom);
            bus_if.flipperSpeedX = spd_t'(int'($urandom_range(0, 3000)) - 1500);
            bus_if.impulseValid  = N'($urandom) & N'($urandom) & N'($urandom) & N'($urandom);
            bus_if.impulseX      = spd_t'(int'($urandom_range(0, 3000)) - 1500);
            bus_if.impulseY      = spd_t'(int'($urandom_range(0, 3000)) - 1500);
            tick();
        end
        clear_inputs();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
